// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB master arbiter: transfer-type encoding, burst constant
// and the address/data pipeline occupancy states.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        PIPE = 2'b11,
        DATA = 2'b10
    } arb_state_t;

    function automatic arb_state_t state_of(input logic a_full, input logic d_full);
        arb_state_t s;
        case ({a_full, d_full})
            2'b10:   s = ADDR;
            2'b11:   s = PIPE;
            2'b01:   s = DATA;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational one-hot grant: first asserted request found when scanning upward
// from the pointer and wrapping; a pointer tied to zero gives fixed priority.
module ahb_arb_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o
);

    localparam int IDW = $clog2(NUM_REQ);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int s;
            s = int'(ptr_i) + off;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (!found && req_i[IDW'(s)]) begin
                found            = 1'b1;
                gnt_o[IDW'(s)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master port among NUM_REQ requesters, one SINGLE transfer per request.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise requester 0 wins.
module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [3*NUM_REQ-1:0]         req_size,
    input  logic [AHB_AW*NUM_REQ-1:0]    req_addr,
    input  logic [AHB_DW*NUM_REQ-1:0]    req_wdata,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [AHB_DW-1:0]            rsp_rdata,
    output logic [AHB_AW-1:0]            haddr,
    output logic                         hwrite,
    output logic [2:0]                   hsize,
    output logic [2:0]                   hburst,
    output logic [1:0]                   htrans,
    output logic [AHB_DW-1:0]            hwdata,
    input  logic [AHB_DW-1:0]            hrdata,
    input  logic                         hready
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t        state_q, state_d;
    htrans_t           htrans_q;
    logic [AHB_AW-1:0] haddr_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [AHB_DW-1:0] hwdata_q;
    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [AHB_DW-1:0] rsp_rdata_q;

    logic [AHB_DW-1:0] a_wdata_q;
    logic [IDW-1:0]    a_id_q;
    logic              d_write_q;
    logic [IDW-1:0]    d_id_q;

    logic a_full, d_full, a_adv, d_done, a_can_load, load, a_full_d, d_full_d;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     ptr;
    logic [AHB_AW-1:0]  sel_addr;
    logic               sel_write;
    logic [2:0]         sel_size;
    logic [AHB_DW-1:0]  sel_wdata;
    logic [IDW-1:0]     sel_id;

    assign a_full     = (state_q == ADDR) || (state_q == PIPE);
    assign d_full     = (state_q == PIPE) || (state_q == DATA);
    assign a_adv      = a_full && hready;
    assign d_done     = d_full && hready;
    assign a_can_load = !a_full || hready;

    ahb_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (pick_gnt)
    );

    // Grant is held off while reset is asserted so req_ready shows its reset value.
    assign req_ready = (reset_n && a_can_load) ? pick_gnt : '0;
    assign load      = |req_ready;

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_wdata = '0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = req_addr[i*AHB_AW +: AHB_AW];
                sel_write = req_write[i];
                sel_size  = req_size[i*3 +: 3];
                sel_wdata = req_wdata[i*AHB_DW +: AHB_DW];
                sel_id    = IDW'(i);
            end
        end
    end

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= (sel_id == IDW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        a_full_d = load || (a_full && !hready);
        d_full_d = a_adv || (d_full && !hready);
        state_d  = state_of(a_full_d, d_full_d);
    end

    // Address-phase bus signals double as the A-stage registers, so they hold when A empties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            htrans_q <= a_full_d ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (load) begin
                haddr_q  <= sel_addr;
                hwrite_q <= sel_write;
                hsize_q  <= sel_size;
            end
            if (a_adv && hwrite_q) begin
                hwdata_q <= a_wdata_q;
            end
            rsp_valid_q <= d_done;
            if (d_done) begin
                rsp_id_q    <= d_id_q;
                rsp_rdata_q <= d_write_q ? '0 : hrdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_wdata_q <= sel_wdata;
            a_id_q    <= sel_id;
        end
        if (a_adv) begin
            d_write_q <= hwrite_q;
            d_id_q    <= a_id_q;
        end
    end

    assign htrans    = htrans_q;
    assign hburst    = HBURST_SINGLE;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Shares a single AHB master port among `NUM_REQ` local requesters, turning each accepted request into one AHB SINGLE transfer. It sits in front of the AHB master interface in the ahb2apb environment. It drives the address phase, the data phase and the pipelined overlap between them. Read data and write completions are returned to the originating requester, tagged with its index.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `AHB_AW`, 32: address width.
- `AHB_DW`, 32: data width.
- `clk` in 1: bus clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_ready` out NUM_REQ: one-hot; bit i high = request i accepted this cycle.
- `req_write` in NUM_REQ: 1 = write.
- `req_size` in 3*NUM_REQ: HSIZE per requester, packed with requester i at [3i+2:3i].
- `req_addr` in AHB_AW*NUM_REQ: address per requester, packed.
- `req_wdata` in AHB_DW*NUM_REQ: write data per requester, packed.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_id` out $clog2(NUM_REQ): requester index of the completion.
- `rsp_rdata` out AHB_DW: captured HRDATA. Zero for writes.
- `haddr` out AHB_AW, `hwrite` out 1, `hsize` out 3, `hburst` out 3, `htrans` out 2, `hwdata` out AHB_DW: AHB master outputs.
- `hrdata` in AHB_DW, `hready` in 1: AHB slave responses.

## Operation
- Two pipeline registers, each with a valid flag:
  - address stage (A): addr, write, size, wdata, id.
  - data stage (D): write, wdata, id.
- States:
  - IDLE: A and D empty.
  - ADDR: A full, D empty.
  - PIPE: A and D full.
  - DATA: A empty, D full.
- A can load when A is empty, or when A is full and `hready`=1 (its address phase completes this edge).
- When A can load and any `req_valid` is high, the arbiter grants one requester:
  - `req_ready[g]`=1 combinationally in that cycle.
  - A captures the request at the edge.
- On an edge with A full and `hready`=1, A moves into D. If D is full with `hready`=1 at the same edge, that transfer completes simultaneously.
- On an edge with D full and `hready`=1:
  - the transfer completes;
  - `rsp_valid`=1 next cycle with `rsp_id`=D.id;
  - `rsp_rdata` is the `hrdata` sampled at that edge, or 0 for a write.
- Outputs while A is full:
  - `htrans`=NONSEQ (2'b10), `hburst`=SINGLE (3'b000);
  - `haddr`/`hwrite`/`hsize` from A.
- Outputs while A is empty: `htrans`=IDLE (2'b00); `haddr`/`hwrite`/`hsize` hold their last values.
- `hwdata` = D.wdata while D is full and a write; otherwise it holds.
- Address-phase signals never change while A is full and `hready`=0.
- Reset values: `htrans`=2'b00; `haddr`, `hwdata`, `hsize`, `hburst`, `hwrite` = 0; `req_ready`=0; `rsp_valid`=0, `rsp_id`=0, `rsp_rdata`=0.
- Reset asserted mid-transfer: A and D are dropped, no response is issued, and the round-robin pointer returns to 0.
- Requesters hold `req_valid` and their request fields stable until accepted. Withdrawing a request before acceptance is legal.

## Timing
- Grant-to-bus: request accepted in cycle N → NONSEQ on the bus in cycle N+1.
- With zero wait states, `rsp_valid` in cycle N+3 (data phase in N+2, completion edge at end of N+2).
- Each cycle of `hready`=0 adds one cycle.
- Back-to-back throughput: one transfer per cycle while `hready`=1 and requests are pending. The address phase of transfer k+1 overlaps the data phase of transfer k.
- Arbitration decision and `req_ready` are combinational from `req_valid` and the pointer. All other outputs are registered.

## Configuration
- `AHB_ARB_ROUND_ROBIN_EN` defined:
  - round-robin priority;
  - after a grant to g, the pointer becomes (g+1) mod NUM_REQ;
  - the search starts at the pointer.
- Not defined:
  - fixed priority, requester 0 highest;
  - no pointer register.

## Structure
- Package `ahb_arb_pkg`:
  - `htrans_t` enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - `HBURST_SINGLE` constant;
  - `arb_state_t` enum (IDLE, ADDR, PIPE, DATA).
- Sub-module `ahb_arb_picker`: combinational one-hot grant from request vector and pointer, shared by both configurations.

## Test plan
- Single read, requester 2, addr 0x100, `hready`=1, `hrdata`=0xCAFE → NONSEQ at 0x100 one cycle after accept; `rsp_valid` with id 2, rdata 0xCAFE three cycles after accept.
- Requesters 0 and 1 issue writes 0x10/0xAA and 0x20/0xBB back-to-back, `hready`=1 → addr 0x20 is on the bus in the same cycle `hwdata`=0xAA; two responses on consecutive cycles.
- Read stalled with `hready`=0 for 3 cycles during its address phase → `haddr`, `htrans`, `hsize` held constant; response delayed by exactly 3 cycles.
- All 4 requesters permanently valid, round-robin enabled → grant order 0,1,2,3,0. Macro undefined → requester 0 granted every cycle.
- `reset_n` pulsed low while a transfer is in PIPE → outputs at reset values immediately; no `rsp_valid`; next grant goes to requester 0.
